// File: rtl/uart_rx_fifo_if.sv
// Bus between a UART receiver front-end, its receive FIFO and the consumer.
// Latency: none, this is only wiring.
// Backpressure: the slave holds rx_clr_dv high until rx_dv drops; the consumer pops with rd_en.
// Ports seen by the slave (the FIFO):
//   in : rx_data, rx_dv (receiver), rd_en (consumer pop), clr_ovr (clear sticky overrun)
//   out: rx_clr_dv (to receiver), dout, empty, full, count, overrun
interface uart_rx_fifo_if #(
    parameter int bits = 8,
    parameter int exp  = 4
);
    logic [bits-1:0] rx_data;
    logic            rx_dv;
    logic            rx_clr_dv;
    logic            rd_en;
    logic [bits-1:0] dout;
    logic            empty;
    logic            full;
    logic [exp:0]    count;
    logic            overrun;
    logic            clr_ovr;

    modport master (
        output rx_data, rx_dv, rd_en, clr_ovr,
        input  rx_clr_dv, dout, empty, full, count, overrun
    );

    modport slave (
        input  rx_data, rx_dv, rd_en, clr_ovr,
        output rx_clr_dv, dout, empty, full, count, overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: captures one character per rx_dv assertion into a 2^exp entry FWFT FIFO.
// Latency: empty falls 4 clk after rx_dv rises at the synchronizer input.
// Backpressure: a write into a full FIFO without a same-cycle pop is dropped and sets sticky overrun.
// Ports: clk_i (rising edge), rst_ni (synchronous, active-low), bus (uart_rx_fifo_if.slave).
module uart_rx_fifo #(
    parameter int bits = 8,
    parameter int exp  = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    uart_rx_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << exp;

    typedef enum logic [1:0] {IDLE, CAPTURE, CLEAR} state_t;

    state_t          state_q;
    logic            sync1_q;
    logic            sync2_q;
    logic            rx_clr_dv_q;

    logic [bits-1:0] mem [DEPTH];
    logic [exp-1:0]  wr_ptr_q, wr_ptr_d;
    logic [exp-1:0]  rd_ptr_q, rd_ptr_d;
    logic [exp:0]    count_q, count_d;
    logic            empty_q;
    logic            full_q;
    logic            ovr_q, ovr_d;
    logic [bits-1:0] dout_q, dout_d;

    logic            wr_req;
    logic            do_pop;
    logic            do_wr;
    logic            ovr_set;

    // rx_dv comes from the baud-clock domain; rx_data is only sampled in
    // CAPTURE, two synchronizer stages after rx_dv rose, so it is settled.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            state_q     <= IDLE;
            rx_clr_dv_q <= 1'b0;
        end else begin
            sync1_q <= bus.rx_dv;
            sync2_q <= sync1_q;
            case (state_q)
                IDLE: begin
                    rx_clr_dv_q <= 1'b0;
                    if (sync2_q) state_q <= CAPTURE;
                end
                CAPTURE: begin
                    rx_clr_dv_q <= 1'b1;
                    state_q     <= CLEAR;
                end
                CLEAR: begin
                    // Waiting for rx_dv to drop guarantees one write per assertion.
                    if (!sync2_q) begin
                        state_q     <= IDLE;
                        rx_clr_dv_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rx_clr_dv_q <= 1'b0;
                end
            endcase
        end
    end

    assign wr_req = (state_q == CAPTURE);

    always_comb begin
        do_pop   = bus.rd_en && !empty_q;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        do_wr    = wr_req && (!full_q || do_pop);
        ovr_set  = wr_req && full_q && !do_pop;

        wr_ptr_d = wr_ptr_q + exp'(do_wr);
        rd_ptr_d = rd_ptr_q + exp'(do_pop);

        count_d  = count_q;
        case ({do_wr, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Registered FWFT head: a write into an (effectively) empty FIFO
        // bypasses memory; otherwise the head is the entry at the next read pointer.
        dout_d = dout_q;
        if (do_wr && ((count_q - (exp+1)'(do_pop)) == '0)) begin
            dout_d = bus.rx_data;
        end else if (count_d != '0) begin
            dout_d = mem[rd_ptr_d];
        end

        // Set has priority over clear.
        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (bus.clr_ovr) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // Storage is not reset; the write is gated so an abandoned capture leaves no trace.
    always_ff @(posedge clk_i) begin
        if (rst_ni && do_wr) begin
            mem[wr_ptr_q] <= bus.rx_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovr_q    <= 1'b0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= (count_d == '0);
            full_q   <= (count_d == (exp+1)'(DEPTH));
            ovr_q    <= ovr_d;
            dout_q   <= dout_d;
        end
    end

    assign bus.rx_clr_dv = rx_clr_dv_q;
    assign bus.dout      = dout_q;
    assign bus.empty     = empty_q;
    assign bus.full      = full_q;
    assign bus.count     = count_q;
    assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: table-driven handshake vectors, directed corner
// sequences and randomized traffic checked against a queue-based reference.
module tb_uart_rx_fifo;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.bits(8), .exp(4)) ifc();

    uart_rx_fifo #(.bits(8), .exp(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (ifc)
    );

    int checks   = 0;
    int failures = 0;

    // Reference: a queue of stored characters, a sticky flag, and a countdown
    // from an rx_dv rising edge to the clock edge where the write attempt lands
    // (two synchronizer stages, one IDLE decision, one CAPTURE cycle).
    logic [7:0] mq[$];
    logic       m_ovr   = 1'b0;
    int         cd      = 0;
    logic       prev_dv = 1'b0;

    typedef struct {
        logic       dv;
        logic       rd;
        logic       clr;
        logic       e_empty;
        logic [4:0] e_count;
        logic       e_clr_dv;
        logic [7:0] e_dout;
    } vec_t;

    vec_t tbl[11];

    function automatic vec_t mk(input logic dv, input logic rd, input logic clr,
                                input logic e_empty, input logic [4:0] e_count,
                                input logic e_clr_dv, input logic [7:0] e_dout);
        vec_t v;
        v.dv = dv; v.rd = rd; v.clr = clr;
        v.e_empty = e_empty; v.e_count = e_count; v.e_clr_dv = e_clr_dv; v.e_dout = e_dout;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Drive one cycle of inputs, advance one clock edge, update the reference, compare.
    task automatic tick(input logic r, input logic dv, input logic [7:0] d,
                        input logic rd, input logic clr);
        logic attempt;
        logic pop;
        logic set;
        rst_n       = r;
        ifc.rx_dv   = dv;
        ifc.rx_data = d;
        ifc.rd_en   = rd;
        ifc.clr_ovr = clr;
        @(posedge clk);
        attempt = 1'b0;
        set     = 1'b0;
        if (!r) begin
            mq.delete();
            m_ovr   = 1'b0;
            cd      = 0;
            prev_dv = 1'b0;
        end else begin
            if (dv && !prev_dv) cd = 4;
            prev_dv = dv;
            if (cd > 0) begin
                cd--;
                if (cd == 0) attempt = 1'b1;
            end
            pop = rd && (mq.size() > 0);
            if (pop) void'(mq.pop_front());
            if (attempt) begin
                if (mq.size() < 16) mq.push_back(d);
                else                set = 1'b1;
            end
            if (set)      m_ovr = 1'b1;
            else if (clr) m_ovr = 1'b0;
        end
        #1;
        chk("count",   32'(ifc.count),   mq.size());
        chk("empty",   32'(ifc.empty),   32'(mq.size() == 0));
        chk("full",    32'(ifc.full),    32'(mq.size() == 16));
        chk("overrun", 32'(ifc.overrun), 32'(m_ovr));
        if (mq.size() > 0) chk("dout", 32'(ifc.dout), 32'(mq[0]));
        if (!r) begin
            chk("rst_dout",   32'(ifc.dout),      32'd0);
            chk("rst_clr_dv", 32'(ifc.rx_clr_dv), 32'd0);
        end
    endtask

    // One receiver transfer: rx_dv high for 'hold' cycles, low for 'gap'.
    // rd_mode: 0 no pops, 1 random pops, 2 pop only in the CAPTURE cycle.
    task automatic send_char(input logic [7:0] d, input int hold, input int gap, input int rd_mode);
        logic rd;
        for (int i = 0; i < hold; i++) begin
            rd = (rd_mode == 1) ? ($urandom_range(0, 9) < 4) : ((rd_mode == 2) && (i == 3));
            tick(1'b1, 1'b1, d, rd, 1'b0);
            if (hold >= 4) chk("clr_dv_hi", 32'(ifc.rx_clr_dv), 32'(i >= 3));
        end
        for (int j = 0; j < gap; j++) begin
            rd = (rd_mode == 1) ? ($urandom_range(0, 9) < 4) : 1'b0;
            tick(1'b1, 1'b0, d, rd, 1'b0);
            if (hold >= 4) chk("clr_dv_lo", 32'(ifc.rx_clr_dv), 32'(j < 2));
        end
    endtask

    initial begin
        logic [7:0] ev;

        rst_n       = 1'b0;
        ifc.rx_dv   = 1'b0;
        ifc.rx_data = 8'h00;
        ifc.rd_en   = 1'b0;
        ifc.clr_ovr = 1'b0;

        //           dv    rd    clr   empty count  clr_dv dout
        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 8'h00);
        tbl[1]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 8'h00);
        tbl[2]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 8'h00);
        tbl[3]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 8'hA5);
        tbl[4]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 8'hA5);
        tbl[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 8'hA5);
        tbl[6]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 8'hA5);
        tbl[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 8'hA5);
        tbl[8]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 8'h00);
        tbl[9]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 8'h00);
        tbl[10] = mk(1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 8'h00);

        // Reset state
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Handshake timing vectors
        for (int i = 0; i < 11; i++) begin
            tick(1'b1, tbl[i].dv, 8'hA5, tbl[i].rd, tbl[i].clr);
            chk("tbl_empty",  32'(ifc.empty),     32'(tbl[i].e_empty));
            chk("tbl_count",  32'(ifc.count),     32'(tbl[i].e_count));
            chk("tbl_clr_dv", 32'(ifc.rx_clr_dv), 32'(tbl[i].e_clr_dv));
            if (!tbl[i].e_empty) chk("tbl_dout", 32'(ifc.dout), 32'(tbl[i].e_dout));
        end

        // Long rx_dv pulse still yields a single write
        send_char(8'hA5, 20, 3, 0);
        chk("long_pulse_count", 32'(ifc.count), 32'd1);
        chk("long_pulse_dout",  32'(ifc.dout),  32'hA5);
        tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

        // Reads while empty are ignored, following traffic is intact
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        send_char(8'h77, 5, 3, 0);
        chk("after_empty_rd_dout", 32'(ifc.dout), 32'h77);
        tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

        // Fill to 16 then overrun with the 17th character
        for (int k = 0; k < 17; k++) send_char(8'(k), 4, 3, 0);
        chk("fill_full",    32'(ifc.full),    32'd1);
        chk("fill_count",   32'(ifc.count),   32'd16);
        chk("fill_overrun", 32'(ifc.overrun), 32'd1);

        // Clear overrun, then write while full with a pop in the CAPTURE cycle
        tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_ovr", 32'(ifc.overrun), 32'd0);
        send_char(8'h55, 5, 3, 2);
        chk("fullpop_count",   32'(ifc.count),   32'd16);
        chk("fullpop_overrun", 32'(ifc.overrun), 32'd0);
        for (int k = 0; k < 16; k++) begin
            ev = (k < 15) ? 8'(k + 1) : 8'h55;
            chk("fullpop_order", 32'(ifc.dout), 32'(ev));
            tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("drained_empty", 32'(ifc.empty), 32'd1);

        // Randomized interleaved traffic across pointer wrap
        for (int n = 0; n < 40; n++) begin
            send_char(8'($urandom), int'($urandom_range(4, 7)), int'($urandom_range(3, 6)), 1);
            if (ifc.count > 5'd16) chk("count_bound", 32'(ifc.count), 32'd16);
        end
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("rand_drained", 32'(ifc.count), 32'd0);

        // Reset during CLEAR with rx_dv held high, then recapture after release
        send_char(8'h11, 4, 3, 0);
        send_char(8'h22, 4, 3, 0);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
        chk("pre_rst_clr_dv", 32'(ifc.rx_clr_dv), 32'd1);
        chk("pre_rst_count",  32'(ifc.count),     32'd3);
        for (int i = 0; i < 2; i++) tick(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
        chk("rst_empty", 32'(ifc.empty), 32'd1);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
        chk("post_rst_count",  32'(ifc.count),     32'd1);
        chk("post_rst_dout",   32'(ifc.dout),      32'h3C);
        chk("post_rst_clr_dv", 32'(ifc.rx_clr_dv), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
